// File: rtl/i2c_txn_seq_pkg.sv
// Shared I2C master definitions: FSM states, error codes,
// R/W bit values and per-state byte-controller command builder.
package i2c_master_defines;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SADDR,
    ST_REG,
    ST_WDATA,
    ST_RSTART,
    ST_RDATA,
    ST_ABORT,
    ST_FIN
  } txn_st_e;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  // R/W flag occupies bit 0 of the address byte
  localparam logic RW_WR = 1'b0;
  localparam logic RW_RD = 1'b1;

  typedef struct packed {
    logic       sta;
    logic       sto;
    logic       rd;
    logic       wr;
    logic       ack;
    logic [7:0] txr;
  } cmd_t;

  // All flags low; Txr keeps its last value
  function automatic cmd_t cmd_off(input logic [7:0] t);
    cmd_t c;
    c     = '0;
    c.txr = t;
    return c;
  endfunction

  function automatic cmd_t cmd_for(
    input txn_st_e    s,
    input logic [6:0] sa,
    input logic [7:0] ra,
    input logic [7:0] wd,
    input logic [7:0] t
  );
    cmd_t c;
    c = cmd_off(t);
    case (s)
      ST_SADDR: begin
        c.sta = 1'b1;
        c.wr  = 1'b1;
        c.txr = {sa, RW_WR};
      end
      ST_REG: begin
        c.wr  = 1'b1;
        c.txr = ra;
      end
      ST_WDATA: begin
        c.wr  = 1'b1;
        c.sto = 1'b1;
        c.txr = wd;
      end
      ST_RSTART: begin
        c.sta = 1'b1;
        c.wr  = 1'b1;
        c.txr = {sa, RW_RD};
      end
      ST_RDATA: begin
        c.rd  = 1'b1;
        c.sto = 1'b1;
        c.ack = 1'b1;
      end
      ST_ABORT: c.sto = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_txn_watchdog.sv
// Per-command watchdog: counts cycles while a command is held.
// Ports: Clk, Rst, Run (command active), Hit (limit reached). Built only with I2C_TXN_TIMEOUT_EN.
`ifdef I2C_TXN_TIMEOUT_EN
module i2c_txn_watchdog #(
  parameter int LIMIT = 4096,
  parameter int TW    = 13
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Run,
  output logic Hit
);

  logic [TW-1:0] cnt;

  // Cleared whenever no command is held, so each issue restarts it
  always_ff @(posedge Clk) begin
    if (Rst || !Run)
      cnt <= '0;
    else if (!Hit)
      cnt <= cnt + 1'b1;
  end

  assign Hit = Run && (cnt == TW'(LIMIT - 1));

endmodule
`endif

// File: rtl/i2c_txn_seq.sv
// I2C register-transaction sequencer driving a byte controller.
// Ports: Req/Req_* in, Busy/Done/Err/Rdata out, Cmd_*/Tx_ack/Txr to and Byte_done/Rx_ack/I2C_al/Rxr from the byte controller. Option: I2C_TXN_TIMEOUT_EN.
module i2c_txn_seq #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 13
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req,
  input  logic       Req_rw,
  input  logic [6:0] Req_saddr,
  input  logic [7:0] Req_raddr,
  input  logic [7:0] Req_wdata,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] Err,
  output logic [7:0] Rdata,
  output logic       Cmd_start,
  output logic       Cmd_stop,
  output logic       Cmd_read,
  output logic       Cmd_write,
  output logic       Tx_ack,
  output logic [7:0] Txr,
  input  logic       Byte_done,
  input  logic       Rx_ack,
  input  logic       I2C_al,
  input  logic [7:0] Rxr
);

  import i2c_master_defines::*;

  txn_st_e    st;
  cmd_t       cmd;
  logic       gap;
  logic       l_rw;
  logic [6:0] l_sa;
  logic [7:0] l_ra;
  logic [7:0] l_wd;
  logic       to_hit;

  assign Cmd_start = cmd.sta;
  assign Cmd_stop  = cmd.sto;
  assign Cmd_read  = cmd.rd;
  assign Cmd_write = cmd.wr;
  assign Tx_ack    = cmd.ack;
  assign Txr       = cmd.txr;

`ifdef I2C_TXN_TIMEOUT_EN
  logic cmd_run;
  assign cmd_run = cmd.sta | cmd.sto | cmd.rd | cmd.wr;

  i2c_txn_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .TW    (TW)
  ) u_wdog (
    .Clk (Clk),
    .Rst (Rst),
    .Run (cmd_run),
    .Hit (to_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg = TW[0] ^ TIMEOUT_CYCLES[0];
  assign to_hit     = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      st    <= ST_IDLE;
      cmd   <= cmd_off(8'h00);
      gap   <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= ERR_OK;
      Rdata <= 8'h00;
      l_rw  <= 1'b0;
      l_sa  <= 7'h00;
      l_ra  <= 8'h00;
      l_wd  <= 8'h00;
    end else begin
      Done <= 1'b0;
      case (st)
        ST_IDLE: begin
          gap  <= 1'b0;
          Busy <= 1'b0;
          if (Req) begin
            l_rw  <= Req_rw;
            l_sa  <= Req_saddr;
            l_ra  <= Req_raddr;
            l_wd  <= Req_wdata;
            Err   <= ERR_OK;
            Rdata <= 8'h00;
            Busy  <= 1'b1;
            st    <= ST_SADDR;
            cmd   <= cmd_for(ST_SADDR, Req_saddr,
                             Req_raddr, Req_wdata, cmd.txr);
          end
        end
        ST_SADDR, ST_REG, ST_WDATA,
        ST_RSTART, ST_RDATA, ST_ABORT: begin
          if (I2C_al) begin
            st  <= ST_FIN;
            Err <= ERR_AL;
            cmd <= cmd_off(cmd.txr);
            gap <= 1'b0;
          end else if (gap) begin
            cmd <= cmd_for(st, l_sa, l_ra, l_wd, cmd.txr);
            gap <= 1'b0;
          end else if (Byte_done) begin
            cmd <= cmd_off(cmd.txr);
            gap <= 1'b1;
            // Only bytes we transmitted can be NACKed
            if (cmd.wr && Rx_ack) begin
              st  <= ST_ABORT;
              Err <= ERR_NACK;
            end else begin
              case (st)
                ST_SADDR:  st <= ST_REG;
                ST_REG:    st <= l_rw ? ST_RSTART : ST_WDATA;
                ST_RSTART: st <= ST_RDATA;
                ST_RDATA: begin
                  Rdata <= Rxr;
                  st    <= ST_FIN;
                end
                default:   st <= ST_FIN;
              endcase
            end
          end else if (to_hit) begin
            st  <= ST_FIN;
            Err <= ERR_TO;
            cmd <= cmd_off(cmd.txr);
          end
        end
        ST_FIN: begin
          Done <= 1'b1;
          Busy <= 1'b0;
          gap  <= 1'b0;
          st   <= ST_IDLE;
        end
        default: begin
          st   <= ST_IDLE;
          Busy <= 1'b0;
          gap  <= 1'b0;
          cmd  <= cmd_off(cmd.txr);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_seq.sv
// Bench for i2c_txn_seq: directed and random transactions against a
// byte-list reference model with a responsive byte-controller stub.
module tb_i2c_txn_seq;

  logic       Clk = 1'b0;
  logic       Rst, Req, Req_rw;
  logic [6:0] Req_saddr;
  logic [7:0] Req_raddr, Req_wdata;
  logic       Busy, Done;
  logic [1:0] Err;
  logic [7:0] Rdata;
  logic       Cmd_start, Cmd_stop, Cmd_read, Cmd_write;
  logic       Tx_ack;
  logic [7:0] Txr;
  logic       Byte_done, Rx_ack, I2C_al;
  logic [7:0] Rxr;

  int total = 0;
  int bad   = 0;

  localparam int TO = 16;

  always #5 Clk = ~Clk;

  i2c_txn_seq #(
    .TIMEOUT_CYCLES (TO),
    .TW             (5)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req       (Req),
    .Req_rw    (Req_rw),
    .Req_saddr (Req_saddr),
    .Req_raddr (Req_raddr),
    .Req_wdata (Req_wdata),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .Rdata     (Rdata),
    .Cmd_start (Cmd_start),
    .Cmd_stop  (Cmd_stop),
    .Cmd_read  (Cmd_read),
    .Cmd_write (Cmd_write),
    .Tx_ack    (Tx_ack),
    .Txr       (Txr),
    .Byte_done (Byte_done),
    .Rx_ack    (Rx_ack),
    .I2C_al    (I2C_al),
    .Rxr       (Rxr)
  );

  logic [12:0] exp_q[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // {start, stop, read, write, tx_ack, byte}; byte only meaningful on writes
  function automatic logic [12:0] mk(input logic sta, sto, rd, wr, ack,
                                     input logic [7:0] t);
    return {sta, sto, rd, wr, ack, wr ? t : 8'h00};
  endfunction

  function automatic logic [12:0] cur();
    return mk(Cmd_start, Cmd_stop, Cmd_read, Cmd_write, Tx_ack, Txr);
  endfunction

  function automatic logic cmd_any();
    return Cmd_start | Cmd_stop | Cmd_read | Cmd_write;
  endfunction

  task automatic chk_rst(input string tag);
    chk(tag, {Busy, Done, Err, Rdata, Cmd_start, Cmd_stop,
              Cmd_read, Cmd_write, Tx_ack, Txr}, 32'h0);
  endtask

  // One transaction. nack_k / al_k / rst_k: byte index of the event, -1 none.
  task automatic txn(input logic rw, input logic [6:0] sa,
                     input logic [7:0] ra, input logic [7:0] wd,
                     input logic [7:0] rx,
                     input int nack_k, input int al_k, input int rst_k,
                     input bit hold_req);
    logic [1:0] e_err;
    int n;
    int lat;
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 1, 0, {sa, 1'b0}));
    exp_q.push_back(mk(0, 0, 0, 1, 0, ra));
    if (!rw) begin
      exp_q.push_back(mk(0, 1, 0, 1, 0, wd));
    end else begin
      exp_q.push_back(mk(1, 0, 0, 1, 0, {sa, 1'b1}));
      exp_q.push_back(mk(0, 1, 1, 0, 1, 8'h00));
    end
    e_err = 2'b00;
    if (al_k >= 0) begin
      while (exp_q.size() > al_k + 1) void'(exp_q.pop_back());
      e_err = 2'b10;
    end else if (nack_k >= 0) begin
      while (exp_q.size() > nack_k + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
      e_err = 2'b01;
    end

    Req = 1'b1; Req_rw = rw; Req_saddr = sa;
    Req_raddr = ra; Req_wdata = wd;
    tick();
    chk("busy_on", {31'h0, Busy}, 1);
    if (hold_req) begin
      Req_rw = ~rw; Req_saddr = ~sa;
      Req_raddr = ~ra; Req_wdata = ~wd;
    end else begin
      Req = 1'b0;
    end

    for (int k = 0; k < exp_q.size(); k++) begin
      n = 0;
      if (k == 0)
        while (!cmd_any() && n < 4) begin tick(); n++; end
      chk($sformatf("cmd%0d", k), {19'h0, cur()}, {19'h0, exp_q[k]});
      if (k == rst_k) begin
        Rst = 1'b1; Req = 1'b0;
        tick();
        Rst = 1'b0;
        chk_rst("rst_mid");
        repeat (4) begin
          tick();
          chk("no_done", {31'h0, Done}, 0);
        end
        return;
      end
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        tick();
        chk($sformatf("hold%0d", k), {19'h0, cur()}, {19'h0, exp_q[k]});
      end
      Byte_done = 1'b1;
      Rx_ack = (k == nack_k) ? 1'b1 :
               (exp_q[k][9] ? 1'b0 : 1'($urandom_range(0, 1)));
      I2C_al = (k == al_k);
      Rxr    = rx;
      tick();
      Byte_done = 1'b0; Rx_ack = 1'b0; I2C_al = 1'b0;
      Rxr = 8'($urandom);
      chk("gap", {31'h0, cmd_any()}, 0);
      chk("no_early_done", {31'h0, Done}, 0);
      if (k == exp_q.size() - 1) Req = 1'b0;
      else tick();
    end

    tick();
    chk("done", {31'h0, Done}, 1);
    chk("err", {30'h0, Err}, {30'h0, e_err});
    chk("busy_off", {31'h0, Busy}, 0);
    chk("cmd_idle", {31'h0, cmd_any()}, 0);
    if (rw && e_err == 2'b00)
      chk("rdata", {24'h0, Rdata}, {24'h0, rx});
    tick();
    chk("done_pulse", {31'h0, Done}, 0);
    chk("err_hold", {30'h0, Err}, {30'h0, e_err});
    chk("stay_idle", {31'h0, Busy}, 0);
  endtask

  initial begin
    int n;
    logic rw;
    int mode;
    Rst = 1'b1; Req = 1'b0; Req_rw = 1'b0; Req_saddr = 7'h00;
    Req_raddr = 8'h00; Req_wdata = 8'h00; Byte_done = 1'b0;
    Rx_ack = 1'b0; I2C_al = 1'b0; Rxr = 8'h00;
    repeat (2) tick();
    chk_rst("reset");
    Rst = 1'b0;
    tick();
    chk_rst("idle");

    // Reset beats a simultaneous request
    Rst = 1'b1; Req = 1'b1;
    tick();
    chk("rst_prio", {31'h0, Busy}, 0);
    Rst = 1'b0; Req = 1'b0;
    tick();

    txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, -1, -1, -1, 1'b0);
    txn(1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, -1, -1, -1, 1'b0);
    txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00,  0, -1, -1, 1'b0);
    txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, -1,  1, -1, 1'b0);
    txn(1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, -1, -1,  3, 1'b0);
    txn(1'b1, 7'h2B, 8'h77, 8'h00, 8'hE1, -1, -1, -1, 1'b1);

`ifdef I2C_TXN_TIMEOUT_EN
    Req = 1'b1; Req_rw = 1'b0; Req_saddr = 7'h50;
    Req_raddr = 8'h12; Req_wdata = 8'hA5;
    tick();
    n = 0;
    while (!cmd_any() && n < 4) begin tick(); n++; end
    n = 0;
    while (cmd_any() && n < 40) begin tick(); n++; end
    Req = 1'b0;
    chk("to_len", n, TO);
    tick();
    chk("to_done", {31'h0, Done}, 1);
    chk("to_err", {30'h0, Err}, 32'h3);
    tick();
`else
    Req = 1'b1; Req_rw = 1'b0; Req_saddr = 7'h50;
    Req_raddr = 8'h12; Req_wdata = 8'hA5;
    tick();
    Req = 1'b0;
    repeat (40) tick();
    chk("no_to", {19'h0, cur()}, {19'h0, mk(1, 0, 0, 1, 0, 8'hA0)});
    chk("no_to_done", {31'h0, Done}, 0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk_rst("no_to_rst");
    tick();
`endif

    repeat (25) begin
      rw   = 1'($urandom);
      mode = $urandom_range(0, 3);
      txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
          (mode == 2) ? $urandom_range(0, 2) : -1,
          (mode == 3) ? $urandom_range(0, rw ? 3 : 2) : -1,
          -1, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
